// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit path: the one-hot serializer
// state encoding (identical to the RX FSM encoding), the parity method
// encoding and small bit-selection / parity helpers.
package uart_tx_serializer_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [4:0] {
    ST_INTERVAL  = 5'b0_0001,
    ST_STARTBIT  = 5'b0_0010,
    ST_DATABITS  = 5'b0_0100,
    ST_PARITYBIT = 5'b0_1000,
    ST_STOPBIT   = 5'b1_0000
  } txState_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Picks data bit number idx in transmission order (bit0 first, or bit7 first).
  function automatic logic selectBit(input logic [7:0] data, input logic [2:0] idx,
                                     input logic bigEnd);
    logic [2:0] pos;
    pos = bigEnd ? (3'd7 - idx) : idx;
    return data[pos];
  endfunction

  // Parity bit that makes the total count of ones even or odd.
  function automatic logic parityBit(input logic [7:0] data, input logic method);
    return (method == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_prefetch.sv
// One-byte prefetch stage between the TX FIFO and the serializer. Issues a
// single-cycle active-low read strobe whenever the holding register is empty,
// captures the FIFO data two clocks later and flags it valid until the
// serializer takes it.
module uart_tx_prefetch
  import uart_tx_serializer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       p_Enable_i,
  input  logic       p_Empty_i,
  input  logic [7:0] Data_i,
  input  logic       take_i,
  output logic       n_Rd_o,
  output logic       holdValid_o,
  output logic [7:0] holdData_o
);

  logic       nRd_q, nRd_d;
  logic       capture_q, capture_d;
  logic       holdValid_q, holdValid_d;
  logic [7:0] holdData_q, holdData_d;
  logic       fetchPending;

  // A fetch is in flight from the strobe cycle until the data has been captured.
  assign fetchPending = ~nRd_q | capture_q;

  // Decide the next read strobe, the capture slot and the holding register contents.
  always_comb begin
    nRd_d       = 1'b1;
    capture_d   = ~nRd_q;
    holdValid_d = holdValid_q;
    holdData_d  = holdData_q;
    if (!holdValid_q && !fetchPending && p_Enable_i && !p_Empty_i) begin
      nRd_d = 1'b0;
    end
    if (capture_q) begin
      holdData_d  = Data_i;
      holdValid_d = 1'b1;
    end else if (take_i) begin
      holdValid_d = 1'b0;
    end
  end

  // Prefetch registers; reset leaves the holding register empty and the strobe idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nRd_q       <= 1'b1;
      capture_q   <= 1'b0;
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
    end else begin
      nRd_q       <= nRd_d;
      capture_q   <= capture_d;
      holdValid_q <= holdValid_d;
      holdData_q  <= holdData_d;
    end
  end

  assign n_Rd_o      = nRd_q;
  assign holdValid_o = holdValid_q;
  assign holdData_o  = holdData_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: takes bytes from the prefetch holding register and
// shifts them onto the tx wire as start, 8 data, optional parity and 1 or 2
// stop bits, advancing only on baud strobes. Frame options are captured when
// the start bit begins so a byte is never sent with mixed settings.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_Enable_i,
  input  logic [7:0] Data_i,
  input  logic       p_Empty_i,
  output logic       n_Rd_o,
  input  logic       p_ParityEnable_i,
  input  logic       p_BigEnd_i,
  input  logic       ParityMethod_i,
  input  logic       BaudSig_i,
  output logic       Tx_o,
  output logic [4:0] State_o,
  output logic [3:0] BitCounter_o,
  output logic       p_Busy_o,
  output logic       p_ByteSent_o
);

  // Index of the final stop-bit strobe; anything other than 2 stop bits means 1.
  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  txState_e   state_q, state_d;
  logic       tx_q, tx_d;
  logic [7:0] data_q, data_d;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic       parity_q, parity_d;
  logic       bigEnd_q, bigEnd_d;
  logic       parEn_q, parEn_d;
  logic       stopCnt_q, stopCnt_d;
  logic       byteSent_q, byteSent_d;

  logic       holdValid;
  logic [7:0] holdData;
  logic       canStart;
  logic       lastStop;
  logic       take;

  assign canStart = holdValid & p_Enable_i;
  assign lastStop = (state_q == ST_STOPBIT) && (stopCnt_q == LAST_STOP);
  assign take     = BaudSig_i & canStart & ((state_q == ST_INTERVAL) | lastStop);

  uart_tx_prefetch u_prefetch (
    .clk         (clk),
    .rst         (rst),
    .p_Enable_i  (p_Enable_i),
    .p_Empty_i   (p_Empty_i),
    .Data_i      (Data_i),
    .take_i      (take),
    .n_Rd_o      (n_Rd_o),
    .holdValid_o (holdValid),
    .holdData_o  (holdData)
  );

  // Serializer next state: every change of state and line level waits for a baud strobe.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    data_d     = data_q;
    bitCnt_d   = bitCnt_q;
    parity_d   = parity_q;
    bigEnd_d   = bigEnd_q;
    parEn_d    = parEn_q;
    stopCnt_d  = stopCnt_q;
    byteSent_d = 1'b0;
    if (BaudSig_i) begin
      unique case (state_q)
        ST_INTERVAL: begin
          if (canStart) begin
            state_d  = ST_STARTBIT;
            tx_d     = 1'b0;
            data_d   = holdData;
            parity_d = parityBit(holdData, ParityMethod_i);
            bigEnd_d = p_BigEnd_i;
            parEn_d  = p_ParityEnable_i;
            bitCnt_d = '0;
          end
        end
        ST_STARTBIT: begin
          state_d  = ST_DATABITS;
          tx_d     = selectBit(data_q, 3'd0, bigEnd_q);
          bitCnt_d = '0;
        end
        ST_DATABITS: begin
          if (bitCnt_q == 4'(DATA_BITS - 1)) begin
            bitCnt_d = '0;
            if (parEn_q) begin
              state_d = ST_PARITYBIT;
              tx_d    = parity_q;
            end else begin
              state_d   = ST_STOPBIT;
              tx_d      = 1'b1;
              stopCnt_d = 1'b0;
            end
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
            tx_d     = selectBit(data_q, bitCnt_q[2:0] + 3'd1, bigEnd_q);
          end
        end
        ST_PARITYBIT: begin
          state_d   = ST_STOPBIT;
          tx_d      = 1'b1;
          stopCnt_d = 1'b0;
        end
        ST_STOPBIT: begin
          if (lastStop) begin
            byteSent_d = 1'b1;
            if (canStart) begin
              state_d  = ST_STARTBIT;
              tx_d     = 1'b0;
              data_d   = holdData;
              parity_d = parityBit(holdData, ParityMethod_i);
              bigEnd_d = p_BigEnd_i;
              parEn_d  = p_ParityEnable_i;
              bitCnt_d = '0;
            end else begin
              state_d = ST_INTERVAL;
              tx_d    = 1'b1;
            end
          end else begin
            stopCnt_d = stopCnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = ST_INTERVAL;
          tx_d     = 1'b1;
          bitCnt_d = '0;
        end
      endcase
    end
  end

  // Serializer registers; reset aborts any byte and returns the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INTERVAL;
      tx_q       <= 1'b1;
      data_q     <= '0;
      bitCnt_q   <= '0;
      parity_q   <= 1'b0;
      bigEnd_q   <= 1'b0;
      parEn_q    <= 1'b0;
      stopCnt_q  <= 1'b0;
      byteSent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      data_q     <= data_d;
      bitCnt_q   <= bitCnt_d;
      parity_q   <= parity_d;
      bigEnd_q   <= bigEnd_d;
      parEn_q    <= parEn_d;
      stopCnt_q  <= stopCnt_d;
      byteSent_q <= byteSent_d;
    end
  end

  assign Tx_o         = tx_q;
  assign State_o      = state_q;
  assign BitCounter_o = bitCnt_q;
  assign p_Busy_o     = (state_q != ST_INTERVAL);
  assign p_ByteSent_o = byteSent_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer. Two instances share control inputs:
// dut0 uses one stop bit, dut1 uses two. Each has its own FIFO model. Stimulus
// pushes the hand-computed line frame into an expectation queue; a monitor per
// instance samples the line at each baud strobe and checks whole frames.
module tb_uart_tx_serializer;
  import uart_tx_serializer_pkg::*;

  localparam int BAUD_DIV   = 8;
  localparam int WAIT_LIMIT = 2000;

  // Line bits in transmission order, first bit at position len-1.
  typedef struct {
    logic [11:0] bits;
    int          len;
    bit          nextStart;
  } frame_t;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic enable    = 1'b1;
  logic bigEnd    = 1'b0;
  logic parEn     = 1'b0;
  logic parMethod = PARITY_EVEN;
  logic baud      = 1'b0;

  logic [7:0] dataIn  [2] = '{8'h00, 8'h00};
  logic       emptyIn [2] = '{1'b1, 1'b1};
  wire        nRd  [2];
  wire        tx   [2];
  wire        busy [2];
  wire        sent [2];
  wire  [4:0] st   [2];
  wire  [3:0] bc   [2];

  logic [7:0] fifoQ [2][$];
  frame_t     expQ  [2][$];
  int         rdCount   [2] = '{0, 0};
  int         sentCount [2] = '{0, 0};
  bit         inFrame   [2] = '{1'b0, 1'b0};
  bit         rdDuringReset = 1'b0;

  int checkCount = 0;
  int passCount  = 0;

  uart_tx_serializer #(.STOP_BITS(1)) dut0 (
    .clk              (clk),
    .rst              (rst),
    .p_Enable_i       (enable),
    .Data_i           (dataIn[0]),
    .p_Empty_i        (emptyIn[0]),
    .n_Rd_o           (nRd[0]),
    .p_ParityEnable_i (parEn),
    .p_BigEnd_i       (bigEnd),
    .ParityMethod_i   (parMethod),
    .BaudSig_i        (baud),
    .Tx_o             (tx[0]),
    .State_o          (st[0]),
    .BitCounter_o     (bc[0]),
    .p_Busy_o         (busy[0]),
    .p_ByteSent_o     (sent[0])
  );

  uart_tx_serializer #(.STOP_BITS(2)) dut1 (
    .clk              (clk),
    .rst              (rst),
    .p_Enable_i       (enable),
    .Data_i           (dataIn[1]),
    .p_Empty_i        (emptyIn[1]),
    .n_Rd_o           (nRd[1]),
    .p_ParityEnable_i (parEn),
    .p_BigEnd_i       (bigEnd),
    .ParityMethod_i   (parMethod),
    .BaudSig_i        (baud),
    .Tx_o             (tx[1]),
    .State_o          (st[1]),
    .BitCounter_o     (bc[1]),
    .p_Busy_o         (busy[1]),
    .p_ByteSent_o     (sent[1])
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // One-clock baud strobe every BAUD_DIV clocks, changed on the falling edge.
  initial begin
    forever begin
      repeat (BAUD_DIV - 1) @(negedge clk);
      baud = 1'b1;
      @(negedge clk);
      baud = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int g, input logic [7:0] b, input logic [11:0] bits,
                               input int len, input bit nextStart);
    frame_t e;
    e.bits      = bits;
    e.len       = len;
    e.nextStart = nextStart;
    expQ[g].push_back(e);
    fifoQ[g].push_back(b);
  endtask

  // FIFO model: a low strobe seen in a cycle delivers data in the following cycle.
  task automatic fifoLoop(input int g);
    forever begin
      @(negedge clk);
      if (nRd[g] === 1'b0) begin
        if (rst) rdDuringReset = 1'b1;
        rdCount[g]++;
        @(posedge clk);
        #1;
        if (fifoQ[g].size() != 0) dataIn[g] = fifoQ[g].pop_front();
        else dataIn[g] = 8'hEE;
      end
      emptyIn[g] = (fifoQ[g].size() == 0);
    end
  endtask

  // Monitor: collects one line sample per baud period and checks each finished frame.
  task automatic monitorLoop(input int g);
    frame_t      e;
    logic [11:0] seqBits;
    int          got;
    logic        b;
    seqBits = '0;
    got     = 0;
    e.bits  = '0;
    e.len   = 0;
    e.nextStart = 1'b0;
    forever begin
      @(posedge clk);
      b = baud;
      #1;
      if (sent[g] === 1'b1) sentCount[g]++;
      if (rst) begin
        inFrame[g] = 1'b0;
        continue;
      end
      if (!b) continue;
      if (inFrame[g] && got == e.len) begin
        checkOutput($sformatf("frameBits_dut%0d", g), 32'(seqBits), 32'(e.bits));
        checkOutput($sformatf("byteSentAtEnd_dut%0d", g), 32'(sent[g]), 32'd1);
        checkOutput($sformatf("stateAfterStop_dut%0d", g), 32'(st[g]),
                    e.nextStart ? 32'(ST_STARTBIT) : 32'(ST_INTERVAL));
        inFrame[g] = 1'b0;
      end
      if (!inFrame[g] && st[g] == ST_STARTBIT) begin
        checkOutput($sformatf("frameExpected_dut%0d", g), 32'(expQ[g].size() != 0), 32'd1);
        if (expQ[g].size() != 0) begin
          e          = expQ[g].pop_front();
          inFrame[g] = 1'b1;
          got        = 0;
          seqBits    = '0;
        end
      end
      if (inFrame[g]) begin
        seqBits = {seqBits[10:0], tx[g]};
        got++;
      end
    end
  endtask

  initial monitorLoop(0);
  initial monitorLoop(1);
  initial fifoLoop(0);
  initial fifoLoop(1);

  task automatic waitIdle(input int g, input string label);
    bit done;
    done = 1'b0;
    for (int i = 0; i < WAIT_LIMIT && !done; i++) begin
      @(negedge clk);
      if (expQ[g].size() == 0 && !inFrame[g] && st[g] == ST_INTERVAL) done = 1'b1;
    end
    checkOutput({label, "_reachedIdle"}, 32'(done), 32'd1);
  endtask

  task automatic waitState(input int g, input logic [4:0] s, input logic [3:0] count,
                           input string label);
    bit done;
    done = 1'b0;
    for (int i = 0; i < WAIT_LIMIT && !done; i++) begin
      @(negedge clk);
      if (st[g] == s && bc[g] == count) done = 1'b1;
    end
    checkOutput({label, "_reachedState"}, 32'(done), 32'd1);
  endtask

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit txDropped;
    bit leftInterval;
    frame_t e;

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 32'(tx[0]), 32'd1);
    checkOutput("reset_state", 32'(st[0]), 32'(ST_INTERVAL));
    checkOutput("reset_bitCounter", 32'(bc[0]), 32'd0);
    checkOutput("reset_busy", 32'(busy[0]), 32'd0);
    checkOutput("reset_byteSent", 32'(sent[0]), 32'd0);
    checkOutput("reset_nRd", 32'(nRd[0]), 32'd1);
    checkOutput("reset_tx_dut1", 32'(tx[1]), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5, LSB first, even parity.
    $display("[TB] 0xA5 LE even parity");
    rdCount[0] = 0; sentCount[0] = 0;
    bigEnd = 1'b0; parEn = 1'b1; parMethod = PARITY_EVEN;
    applyStimulus(0, 8'hA5, 12'b0_0_10100101_0_1, 11, 1'b0);
    waitIdle(0, "a5le");
    checkOutput("a5le_reads", 32'(rdCount[0]), 32'd1);
    checkOutput("a5le_byteSentPulses", 32'(sentCount[0]), 32'd1);

    // MSB first, no parity: 0xA5 and the asymmetric 0x01.
    $display("[TB] BE no parity");
    rdCount[0] = 0; sentCount[0] = 0;
    bigEnd = 1'b1; parEn = 1'b0;
    applyStimulus(0, 8'hA5, 12'b00_0_10100101_1, 10, 1'b0);
    waitIdle(0, "a5be");
    applyStimulus(0, 8'h01, 12'b00_0_00000001_1, 10, 1'b0);
    waitIdle(0, "01be");
    checkOutput("be_reads", 32'(rdCount[0]), 32'd2);
    checkOutput("be_byteSentPulses", 32'(sentCount[0]), 32'd2);

    // Odd parity; options changed mid-byte must not affect the byte in flight.
    $display("[TB] LE odd parity");
    rdCount[0] = 0; sentCount[0] = 0;
    bigEnd = 1'b0; parEn = 1'b1; parMethod = PARITY_ODD;
    applyStimulus(0, 8'h01, 12'b0_0_10000000_0_1, 11, 1'b0);
    waitState(0, ST_STARTBIT, 4'd0, "01odd");
    @(negedge clk);
    bigEnd = 1'b1; parEn = 1'b0; parMethod = PARITY_EVEN;
    waitIdle(0, "01odd");
    bigEnd = 1'b0; parEn = 1'b1; parMethod = PARITY_ODD;
    applyStimulus(0, 8'h03, 12'b0_0_11000000_1_1, 11, 1'b0);
    waitIdle(0, "03odd");
    checkOutput("odd_reads", 32'(rdCount[0]), 32'd2);

    // Back-to-back bytes with no idle bit between them.
    $display("[TB] back-to-back");
    rdCount[0] = 0; sentCount[0] = 0;
    bigEnd = 1'b0; parEn = 1'b0; parMethod = PARITY_EVEN;
    applyStimulus(0, 8'h11, 12'b00_0_10001000_1, 10, 1'b1);
    applyStimulus(0, 8'h22, 12'b00_0_01000100_1, 10, 1'b0);
    waitIdle(0, "b2b");
    checkOutput("b2b_reads", 32'(rdCount[0]), 32'd2);
    checkOutput("b2b_byteSentPulses", 32'(sentCount[0]), 32'd2);

    // Reset in the middle of the data bits aborts the byte immediately.
    $display("[TB] reset mid-byte");
    rdCount[0] = 0; sentCount[0] = 0;
    applyStimulus(0, 8'h5A, 12'b00_0_01011010_1, 10, 1'b0);
    waitState(0, ST_DATABITS, 4'd3, "midReset");
    #2 rst = 1'b1;
    #1;
    checkOutput("midReset_tx", 32'(tx[0]), 32'd1);
    checkOutput("midReset_state", 32'(st[0]), 32'(ST_INTERVAL));
    checkOutput("midReset_bitCounter", 32'(bc[0]), 32'd0);
    checkOutput("midReset_busy", 32'(busy[0]), 32'd0);
    applyStimulus(0, 8'h77, 12'b00_0_11101110_1, 10, 1'b0);
    repeat (2 * BAUD_DIV + 3) @(negedge clk);
    checkOutput("inReset_tx", 32'(tx[0]), 32'd1);
    checkOutput("inReset_nRd", 32'(nRd[0]), 32'd1);
    rst = 1'b0;
    waitIdle(0, "afterReset");
    checkOutput("afterReset_reads", 32'(rdCount[0]), 32'd2);
    checkOutput("afterReset_byteSentPulses", 32'(sentCount[0]), 32'd1);
    checkOutput("readDuringReset", 32'(rdDuringReset), 32'd0);

    // Two stop bits; enable dropped during the data bits.
    $display("[TB] two stop bits, enable drop");
    rdCount[1] = 0; sentCount[1] = 0;
    bigEnd = 1'b0; parEn = 1'b0; parMethod = PARITY_EVEN;
    applyStimulus(1, 8'h5A, 12'b0_0_01011010_1_1, 11, 1'b0);
    fifoQ[1].push_back(8'h3C);
    waitState(1, ST_DATABITS, 4'd0, "stop2");
    enable = 1'b0;
    waitIdle(1, "stop2First");
    checkOutput("stop2_readsAtDisable", 32'(rdCount[1]), 32'd2);
    txDropped = 1'b0;
    leftInterval = 1'b0;
    repeat (5 * BAUD_DIV) begin
      @(negedge clk);
      if (tx[1] !== 1'b1) txDropped = 1'b1;
      if (st[1] != ST_INTERVAL) leftInterval = 1'b1;
    end
    checkOutput("stop2_txHeldHigh", 32'(txDropped), 32'd0);
    checkOutput("stop2_stayedIdle", 32'(leftInterval), 32'd0);
    checkOutput("stop2_noReadWhileDisabled", 32'(rdCount[1]), 32'd2);
    e.bits = 12'b0_0_00111100_1_1;
    e.len = 11;
    e.nextStart = 1'b0;
    expQ[1].push_back(e);
    enable = 1'b1;
    waitIdle(1, "stop2Second");
    checkOutput("stop2_readsTotal", 32'(rdCount[1]), 32'd2);
    checkOutput("stop2_byteSentPulses", 32'(sentCount[1]), 32'd2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
